// File: rtl/matrix_host_ctrl.sv
// matrix_host_ctrl
// Host-side controller for the 3x3 8-bit matrix multiplier. It collects 18
// operand bytes from a byte stream and holds them on the parallel a*/b* outputs.
// It then pulses start, waits for mm_done (or a timeout) and captures the nine
// results, which it streams out one byte at a time.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data     operand byte stream in (order a00..a22, b00..b22)
//   a00..a22, b00..b22    operand outputs to the multiplier
//   start                 one-cycle start pulse to the multiplier
//   mm_m1..mm_m9, mm_done multiplier results (row-major C00..C22) and done
//   out_valid/out_ready/out_data  result byte stream out (M1..M9)
//   busy                  high in every state except LOAD
//   err                   sticky timeout flag, cleared only by reset
module matrix_host_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22,
  output logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22,
  output logic       start,
  input  logic [7:0] mm_m1, mm_m2, mm_m3, mm_m4, mm_m5, mm_m6, mm_m7, mm_m8, mm_m9,
  input  logic       mm_done,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT, S_DRAIN} state_t;

  // Counter only needs to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state_q, state_d;
  logic [17:0][7:0] ops_q, ops_d;
  logic [8:0][7:0]  res_q, res_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             err_q, err_d;

  logic [8:0][7:0]  mm_vec;
  logic             timeout_hit;

  assign mm_vec      = {mm_m9, mm_m8, mm_m7, mm_m6, mm_m5, mm_m4, mm_m3, mm_m2, mm_m1};
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          ops_d[cnt_q] = in_data;
          if (cnt_q == 5'd17) begin
            cnt_d   = '0;
            state_d = S_FIRE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_FIRE: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        // done wins over a timeout landing in the same cycle
        if (mm_done) begin
          res_d   = mm_vec;
          state_d = S_DRAIN;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == 4'd8) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      ops_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign start     = (state_q == S_FIRE);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_LOAD);
  assign err       = err_q;
  assign out_data  = out_valid ? res_q[idx_q] : 8'h00;

  assign {b22, b21, b20, b12, b11, b10, b02, b01, b00,
          a22, a21, a20, a12, a11, a10, a02, a01, a00} = ops_q;

endmodule
